// File: rtl/product_accumulator_if.sv
// product_accumulator_if: bundle carrying the product input handshake, flush
// pulse, frame-total output handshake and frame status for product_accumulator.
//   master : upstream side (multiplier feed, consumer ready, flush)
//   slave  : the accumulator itself
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender keeps data stable and valid
// asserted until that edge, and the receiver may change ready at any time.
interface product_accumulator_if #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16
);
    logic [PROD_W-1:0] prod;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        beat_cnt;
    logic              ovf;

    modport master (
        output prod, in_valid, flush, out_ready,
        input  in_ready, acc_out, out_valid, beat_cnt, ovf
    );

    modport slave (
        input  prod, in_valid, flush, out_ready,
        output in_ready, acc_out, out_valid, beat_cnt, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums ACC_LEN unsigned products into one frame total and
// holds it on a valid/ready output until the consumer takes it. A flush pulse
// closes a frame early; overflow of ACC_W is flagged per frame in ovf.
// Optional macro ACC_SATURATE_EN: on overflow the total clamps to all ones
// instead of wrapping modulo 2^ACC_W.
// The FSM state is exported on o_state (0=IDLE, 1=ACCUM, 2=HOLD).
module product_accumulator #(
    parameter int PROD_W  = 12,
    parameter int ACC_W   = 16,
    parameter int ACC_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    product_accumulator_if.slave   bus,
    output logic [1:0]             o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LEN_B = 8'(ACC_LEN);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_beat_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_beat;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [ACC_W-1:0]   w_next_acc;
    logic [7:0]         w_cnt_inc;
    logic               w_len_hit;

    assign w_beat    = bus.in_valid & r_in_ready;
    assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(bus.prod);
    assign w_carry   = w_sum[ACC_W];
    assign w_cnt_inc = r_beat_cnt + 8'd1;
    assign w_len_hit = (w_cnt_inc == LEN_B);

    // Next accumulator value for a beat in ACCUM: wrap or clamp on overflow.
    always_comb begin
        w_next_acc = w_sum[ACC_W-1:0];
`ifdef ACC_SATURATE_EN
        if (w_carry || r_ovf) begin
            w_next_acc = {ACC_W{1'b1}};
        end
`endif
    end

    // Frame FSM; in_ready and out_valid are registered so both read 0 in reset.
    // in_ready stays low for the first IDLE cycle after an xfer, giving the
    // one-cycle bubble between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_beat_cnt  <= 8'd0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_acc      <= ACC_W'(bus.prod);
                        r_beat_cnt <= 8'd1;
                        r_ovf      <= 1'b0;
                        if (ACC_LEN == 1 || bus.flush) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc      <= w_next_acc;
                        r_beat_cnt <= w_cnt_inc;
                        r_ovf      <= r_ovf | w_carry;
                    end
                    // A flush with a beat sums the beat first, then closes.
                    if ((w_beat && w_len_hit) || bus.flush) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_beat_cnt  <= 8'd0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_out   = r_acc;
    assign bus.beat_cnt  = r_beat_cnt;
    assign bus.ovf       = r_ovf;
    assign o_state       = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (default, 12-bit accumulator
// with 2-beat frames for overflow, single-beat frames), directed vectors.
module tb_product_accumulator;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(12), .ACC_W(16)) a_if ();
    product_accumulator_if #(.PROD_W(12), .ACC_W(12)) b_if ();
    product_accumulator_if #(.PROD_W(12), .ACC_W(16)) c_if ();
    logic [1:0] a_state, b_state, c_state;

    product_accumulator #(.PROD_W(12), .ACC_W(16), .ACC_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .o_state(a_state));
    product_accumulator #(.PROD_W(12), .ACC_W(12), .ACC_LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .o_state(b_state));
    product_accumulator #(.PROD_W(12), .ACC_W(16), .ACC_LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if), .o_state(c_state));

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    // driver: one beat into dut_a, waiting (bounded) for in_ready
    task automatic beat_a(input logic [11:0] p, input logic f);
        int n;
        a_if.prod     = p;
        a_if.in_valid = 1'b1;
        a_if.flush    = f;
        n = 0;
        @(negedge clk);
        while (!a_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL beat_a_timeout: in_ready=%0b after %0d cycles, want 1", a_if.in_ready, n);
        end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b0;
        a_if.prod     = 12'($urandom_range(0, 4095));
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b0 || a_if.acc_out !== 16'd0 ||
            a_if.beat_cnt !== 8'd0 || a_if.ovf !== 1'b0 || a_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: rdy=%0b vld=%0b acc=%0d cnt=%0d ovf=%0b st=%0d, want all 0",
                     a_if.in_ready, a_if.out_valid, a_if.acc_out, a_if.beat_cnt, a_if.ovf, a_state);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        a_if.out_ready = 1'b1;
        repeat (4) beat_a(12'd3969, 1'b0);
        total++;
        if (a_if.out_valid !== 1'b1 || a_if.acc_out !== 16'd15876 || a_if.beat_cnt !== 8'd4 ||
            a_if.ovf !== 1'b0 || a_state !== ST_HOLD) begin
            bad++;
            $display("FAIL defaults_total: vld=%0b acc=%0d cnt=%0d ovf=%0b st=%0d, want 1 15876 4 0 2",
                     a_if.out_valid, a_if.acc_out, a_if.beat_cnt, a_if.ovf, a_state);
        end
        @(posedge clk);
        #1;
        total++;
        if (a_if.out_valid !== 1'b0 || a_state !== ST_IDLE || a_if.beat_cnt !== 8'd0 ||
            a_if.acc_out !== 16'd15876) begin
            bad++;
            $display("FAIL defaults_xfer: vld=%0b st=%0d cnt=%0d acc=%0d, want 0 0 0 15876",
                     a_if.out_valid, a_state, a_if.beat_cnt, a_if.acc_out);
        end
    endtask

    task automatic test_backpressure();
        a_if.out_ready = 1'b0;
        beat_a(12'd1, 1'b0);
        beat_a(12'd2, 1'b0);
        beat_a(12'd3, 1'b0);
        beat_a(12'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_if.in_valid = 1'b1;
            a_if.prod     = 12'd99;
            @(negedge clk);
            total++;
            if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b1 || a_if.acc_out !== 16'd10) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: rdy=%0b vld=%0b acc=%0d, want 0 1 10",
                         i, a_if.in_ready, a_if.out_valid, a_if.acc_out);
            end
            @(posedge clk);
            #1;
        end
        a_if.in_valid = 1'b0;
        total++;
        if (a_if.beat_cnt !== 8'd4) begin
            bad++;
            $display("FAIL backpressure_cnt: cnt=%0d, want 4", a_if.beat_cnt);
        end
        a_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (a_state !== ST_IDLE || a_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: st=%0d vld=%0b, want 0 0", a_state, a_if.out_valid);
        end
    endtask

    task automatic test_flush();
        beat_a(12'd10, 1'b0);
        beat_a(12'd20, 1'b0);
        a_if.flush = 1'b1;
        @(posedge clk);
        #1 a_if.flush = 1'b0;
        total++;
        if (a_if.out_valid !== 1'b1 || a_if.acc_out !== 16'd30 || a_if.beat_cnt !== 8'd2) begin
            bad++;
            $display("FAIL flush_alone: vld=%0b acc=%0d cnt=%0d, want 1 30 2",
                     a_if.out_valid, a_if.acc_out, a_if.beat_cnt);
        end
        @(posedge clk);
        #1;
        // flush in IDLE without a beat does nothing
        a_if.flush = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 a_if.flush = 1'b0;
        total++;
        if (a_state !== ST_IDLE || a_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_ignored: st=%0d vld=%0b, want 0 0", a_state, a_if.out_valid);
        end
        beat_a(12'd10, 1'b0);
        beat_a(12'd20, 1'b1);
        total++;
        if (a_if.out_valid !== 1'b1 || a_if.acc_out !== 16'd30 || a_if.beat_cnt !== 8'd2) begin
            bad++;
            $display("FAIL flush_with_beat: vld=%0b acc=%0d cnt=%0d, want 1 30 2",
                     a_if.out_valid, a_if.acc_out, a_if.beat_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [11:0] want_acc;
        int n;
`ifdef ACC_SATURATE_EN
        want_acc = 12'd4095;
`else
        want_acc = 12'd3842;
`endif
        b_if.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL overflow_ready_timeout: in_ready=%0b, want 1", b_if.in_ready);
        end
        b_if.prod     = 12'd3969;
        b_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 b_if.in_valid = 1'b0;
        total++;
        if (b_if.out_valid !== 1'b1 || b_if.acc_out !== want_acc || b_if.ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_total: vld=%0b acc=%0d ovf=%0b, want 1 %0d 1",
                     b_if.out_valid, b_if.acc_out, b_if.ovf, want_acc);
        end
        b_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        b_if.prod     = 12'd5;
        b_if.in_valid = 1'b1;
        @(posedge clk);
        #1 b_if.in_valid = 1'b0;
        total++;
        if (b_if.ovf !== 1'b0 || b_if.acc_out !== 12'd5 || b_if.beat_cnt !== 8'd1 || b_state !== ST_ACCUM) begin
            bad++;
            $display("FAIL overflow_clear: ovf=%0b acc=%0d cnt=%0d st=%0d, want 0 5 1 1",
                     b_if.ovf, b_if.acc_out, b_if.beat_cnt, b_state);
        end
        b_if.in_valid = 1'b1;
        @(posedge clk);
        #1 b_if.in_valid = 1'b0;
        total++;
        if (b_if.out_valid !== 1'b1 || b_if.acc_out !== 12'd10 || b_if.ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_next_frame: vld=%0b acc=%0d ovf=%0b, want 1 10 0",
                     b_if.out_valid, b_if.acc_out, b_if.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        a_if.out_ready = 1'b1;
        beat_a(12'd7, 1'b0);
        beat_a(12'd7, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b0 || a_if.acc_out !== 16'd0 ||
            a_if.beat_cnt !== 8'd0 || a_if.ovf !== 1'b0 || a_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_mid_frame: rdy=%0b vld=%0b acc=%0d cnt=%0d ovf=%0b st=%0d, want all 0",
                     a_if.in_ready, a_if.out_valid, a_if.acc_out, a_if.beat_cnt, a_if.ovf, a_state);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) beat_a(12'd5, 1'b0);
        total++;
        if (a_if.out_valid !== 1'b1 || a_if.acc_out !== 16'd20 || a_if.beat_cnt !== 8'd4) begin
            bad++;
            $display("FAIL reset_recover: vld=%0b acc=%0d cnt=%0d, want 1 20 4",
                     a_if.out_valid, a_if.acc_out, a_if.beat_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // single-beat frames streamed back to back: ready/valid pattern repeats
    // every three cycles (beat, hold, bubble); totals checked via exp_q
    task automatic test_back_to_back();
        logic [6:0] exp_r;
        logic [6:0] exp_v;
        logic [15:0] want;
        int n;
        exp_r = 7'b1001001;
        exp_v = 7'b0010010;
        c_if.out_ready = 1'b1;
        exp_q.delete();
        n = 0;
        @(negedge clk);
        while (!c_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL b2b_ready_timeout: in_ready=%0b, want 1", c_if.in_ready);
        end
        c_if.prod     = 12'd777;
        c_if.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (c_if.in_ready !== exp_r[i] || c_if.out_valid !== exp_v[i]) begin
                bad++;
                $display("FAIL b2b_pattern[%0d]: rdy=%0b vld=%0b, want %0b %0b",
                         i, c_if.in_ready, c_if.out_valid, exp_r[i], exp_v[i]);
            end
            if (c_if.in_ready) exp_q.push_back(16'(c_if.prod));
            if (c_if.out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_total[%0d]: acc=%0d with no expected frame", i, c_if.acc_out);
                end else begin
                    want = exp_q.pop_front();
                    if (c_if.acc_out !== want) begin
                        bad++;
                        $display("FAIL b2b_total[%0d]: acc=%0d, want %0d", i, c_if.acc_out, want);
                    end
                end
            end
            @(posedge clk);
            #1 c_if.prod = c_if.prod + 12'd111;
        end
        c_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.prod = '0; a_if.in_valid = 1'b0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
        b_if.prod = '0; b_if.in_valid = 1'b0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;
        c_if.prod = '0; c_if.in_valid = 1'b0; c_if.flush = 1'b0; c_if.out_ready = 1'b0;
        test_reset();
        test_defaults();
        test_backpressure();
        test_flush();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
